ram_writer: RTL and testbench
=============================

RAM_WRITER -- requirements
Module: ram_writer

Interface
REQ-001 The block SHALL have parameter p_data_width, default 8, meaning the RAM word width in bits.
REQ-002 The block SHALL have parameter p_address_width, default 10, meaning the RAM address width; depth is 2**p_address_width words.
REQ-003 The block SHALL have port i_w_clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port i_w_reset, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port i_w_start, input, 1 bit: burst start request, sampled only in IDLE.
REQ-006 The block SHALL have port i_w_base, input, p_address_width bits: first write address of the burst.
REQ-007 The block SHALL have port i_w_count, input, p_address_width bits: number of words in the burst; 0 means an empty burst.
REQ-008 The block SHALL have port i_w_valid, input, 1 bit: i_w_data is valid this cycle.
REQ-009 The block SHALL have port i_w_data, input, p_data_width bits: write data word.
REQ-010 The block SHALL have port o_w_ready, output, 1 bit: the block accepts a data word this cycle.
REQ-011 The block SHALL have port o_w_busy, output, 1 bit: a burst is in progress (state WRITE or DONE).
REQ-012 The block SHALL have port o_w_done, output, 1 bit: single-cycle pulse at burst completion.
REQ-013 The block SHALL have port o_w_wr_address, output, p_address_width bits: the next address to be written.
REQ-014 The block SHALL have port i_w_address, input, p_address_width bits: readback address.
REQ-015 The block SHALL have port i_w_oe, input, 1 bit: readback output enable.
REQ-016 The block SHALL have port o_w_out, output, p_data_width bits: registered readback data.

Function
REQ-017 The FSM SHALL have exactly three states: IDLE, WRITE and DONE.
REQ-018 In IDLE, if i_w_start=1 and i_w_count!=0, the block SHALL latch i_w_base into the write pointer, latch i_w_count into the remaining counter, and enter WRITE on the next edge.
REQ-019 In IDLE, if i_w_start=1 and i_w_count=0, the block SHALL enter DONE directly, write no memory, and leave the pointer at i_w_base.
REQ-020 In WRITE, o_w_ready SHALL be 1; in IDLE and DONE, o_w_ready SHALL be 0.
REQ-021 A word transfers only when i_w_valid=1 and o_w_ready=1 on the same edge; on transfer, mem[pointer] <= i_w_data, the pointer increments, and remaining decrements.
REQ-022 The pointer SHALL wrap modulo 2**p_address_width (all-ones + 1 -> 0), with no error and no stall.
REQ-023 When a transfer occurs with remaining=1, the FSM SHALL go to DONE on that edge.
REQ-024 While i_w_valid=0 in WRITE, the block SHALL hold all state; there is no timeout.
REQ-025 In DONE, o_w_done SHALL be 1 for exactly one cycle, and the FSM SHALL then return to IDLE unconditionally.
REQ-026 i_w_start SHALL be ignored in WRITE and DONE.
REQ-027 o_w_busy SHALL be 1 exactly in WRITE and DONE; o_w_wr_address SHALL continuously show the pointer.
REQ-028 Readback, independent of the FSM: if i_w_oe=1, o_w_out <= mem[i_w_address] at the edge; if i_w_oe=0, o_w_out <= 0. Latency is 1 cycle.
REQ-029 A simultaneous write and read of the same address SHALL return the old data (read-before-write); the new data is visible on the next read.
REQ-030 All outputs SHALL be registered or decoded from registered state only, with no combinational path from any input to any output.

Reset
REQ-031 With i_w_reset=1 at an edge, the FSM SHALL go to IDLE, and the pointer, remaining counter and o_w_out SHALL clear to 0; o_w_ready=0, o_w_busy=0, o_w_done=0, o_w_wr_address=0.
REQ-032 Reset SHALL take priority over start, transfer and readback, including mid-burst; the burst is abandoned, no o_w_done is produced, and words already written stay in memory.
REQ-033 Memory contents SHALL NOT be cleared by reset.

Verification
REQ-034 Burst: base=2, count=3, data 10,11,12 with valid held high -> ready high for 3 cycles, done pulses once, busy falls; readback with oe=1 at addresses 2,3,4 -> 10,11,12, each 1 cycle after the address.
REQ-035 Wrap: base=1022, count=4, data 1..4 -> addresses 1022,1023,0,1 hold 1,2,3,4; o_w_wr_address ends at 2.
REQ-036 Backpressure: count=2 with valid low for 5 cycles between the two words -> state holds and busy stays 1, done arrives only after the second word, and exactly 2 words are written.
REQ-037 Empty and ignored start: count=0 -> done 1 cycle after start, ready never high, memory unchanged; a start pulse during WRITE causes no change.
REQ-038 Reset mid-burst: reset after 1 of 3 words -> next cycle idle, all outputs 0, no done; the first word is still readable.
REQ-039 Readback: oe=0 -> o_w_out=0; a same-cycle write and read of address 5 (old value 7, new value 9) -> reads 7, then 9 on the next read.

Source files
------------

// File: rtl/ram_writer.sv
`default_nettype none
// ============================================================================
// Module   : ram_writer
// Brief    : Burst writer into an on-chip RAM with an independent registered
//            readback port (read-before-write on address collision).
// Revision : 1.0 - initial release
// ============================================================================
module ram_writer #(
    parameter int p_data_width    = 8,
    parameter int p_address_width = 10
) (
    input  logic                       i_w_clk,
    input  logic                       i_w_reset,
    input  logic                       i_w_start,
    input  logic [p_address_width-1:0] i_w_base,
    input  logic [p_address_width-1:0] i_w_count,
    input  logic                       i_w_valid,
    input  logic [p_data_width-1:0]    i_w_data,
    output logic                       o_w_ready,
    output logic                       o_w_busy,
    output logic                       o_w_done,
    output logic [p_address_width-1:0] o_w_wr_address,
    input  logic [p_address_width-1:0] i_w_address,
    input  logic                       i_w_oe,
    output logic [p_data_width-1:0]    o_w_out
);

    localparam int                       C_DEPTH = 1 << p_address_width;
    localparam logic [p_address_width-1:0] C_ZERO  = '0;
    localparam logic [p_address_width-1:0] C_ONE   = {{(p_address_width-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                       r_state;
    logic [p_address_width-1:0]   r_ptr;
    logic [p_address_width-1:0]   r_remaining;
    logic                         r_ready;
    logic                         r_busy;
    logic                         r_done;
    logic [p_data_width-1:0]      r_out;
    logic [p_data_width-1:0]      r_mem [C_DEPTH];

    logic                         w_xfer;

    // r_ready mirrors r_state == WRITE, so this depends only on registered state
    // plus the valid qualifier; it never reaches an output port.
    assign w_xfer = r_ready && i_w_valid;

    always_ff @(posedge i_w_clk) begin
        if (i_w_reset) begin
            r_state     <= IDLE;
            r_ptr       <= C_ZERO;
            r_remaining <= C_ZERO;
            r_ready     <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_w_start) begin
                        r_ptr  <= i_w_base;
                        r_busy <= 1'b1;
                        if (i_w_count != C_ZERO) begin
                            r_remaining <= i_w_count;
                            r_state     <= WRITE;
                            r_ready     <= 1'b1;
                        end else begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                WRITE: begin
                    if (w_xfer) begin
                        r_ptr       <= r_ptr + C_ONE;
                        r_remaining <= r_remaining - C_ONE;
                        if (r_remaining == C_ONE) begin
                            r_state <= DONE;
                            r_ready <= 1'b0;
                            r_done  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_ready <= 1'b0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    // Memory has no reset; reset only suppresses a write on the same edge.
    always_ff @(posedge i_w_clk) begin
        if (!i_w_reset && w_xfer) begin
            r_mem[r_ptr] <= i_w_data;
        end
    end

    always_ff @(posedge i_w_clk) begin
        if (i_w_reset) begin
            r_out <= '0;
        end else if (i_w_oe) begin
            r_out <= r_mem[i_w_address];
        end else begin
            r_out <= '0;
        end
    end

    assign o_w_ready      = r_ready;
    assign o_w_busy       = r_busy;
    assign o_w_done       = r_done;
    assign o_w_wr_address = r_ptr;
    assign o_w_out        = r_out;

endmodule
`default_nettype wire

// File: tb/tb_ram_writer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_ram_writer
// Brief    : Self-checking bench for ram_writer: burst sequences plus a
//            readback vector table checked through an expected-value queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ram_writer;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [9:0] base;
    logic [9:0] count;
    logic       valid;
    logic [7:0] data;
    logic       ready;
    logic       busy;
    logic       done;
    logic [9:0] wr_address;
    logic [9:0] rd_address;
    logic       oe;
    logic [7:0] out;

    int n_vec  = 0;
    int n_fail = 0;
    int ready_cycles;

    logic [7:0] exp_q[$];

    typedef struct {
        logic [9:0] addr;
        logic       oe;
        logic [7:0] exp;
    } rd_vec_t;

    rd_vec_t tbl[13];

    ram_writer #(.p_data_width(8), .p_address_width(10)) dut (
        .i_w_clk        (clk),
        .i_w_reset      (rst),
        .i_w_start      (start),
        .i_w_base       (base),
        .i_w_count      (count),
        .i_w_valid      (valid),
        .i_w_data       (data),
        .o_w_ready      (ready),
        .o_w_busy       (busy),
        .o_w_done       (done),
        .o_w_wr_address (wr_address),
        .i_w_address    (rd_address),
        .i_w_oe         (oe),
        .o_w_out        (out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One clock; any readback queued before the edge is compared after it.
    task automatic step();
        @(posedge clk);
        #1;
        if (exp_q.size() > 0) begin
            check("readback", {24'd0, out}, {24'd0, exp_q.pop_front()});
        end
    endtask

    task automatic issue_read(input logic [9:0] a, input logic e, input logic [7:0] x);
        rd_address = a;
        oe         = e;
        exp_q.push_back(x);
    endtask

    task automatic begin_burst(input logic [9:0] b, input logic [9:0] c);
        start = 1'b1;
        base  = b;
        count = c;
        step();
        start = 1'b0;
    endtask

    task automatic push_word(input logic [7:0] d);
        valid = 1'b1;
        data  = d;
        step();
        valid = 1'b0;
    endtask

    task automatic check_idle(input string name);
        check({name, "_busy"},  {31'd0, busy},  32'd0);
        check({name, "_ready"}, {31'd0, ready}, 32'd0);
        check({name, "_done"},  {31'd0, done},  32'd0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; base = '0; count = '0;
        valid = 1'b0; data = '0; rd_address = '0; oe = 1'b0;
        step();
        step();
        check_idle("reset");
        check("reset_wr_address", {22'd0, wr_address}, 32'd0);
        check("reset_out", {24'd0, out}, 32'd0);
        rst = 1'b0;
        step();

        // Basic burst: base 2, three words, valid held high.
        begin_burst(10'd2, 10'd3);
        check("b1_wr_address", {22'd0, wr_address}, 32'd2);
        ready_cycles = 0;
        for (int i = 0; i < 3; i++) begin
            if (ready) ready_cycles++;
            push_word(8'd10 + 8'(i));
        end
        check("b1_ready_cycles", ready_cycles, 32'd3);
        check("b1_done", {31'd0, done}, 32'd1);
        check("b1_busy_in_done", {31'd0, busy}, 32'd1);
        check("b1_ready_in_done", {31'd0, ready}, 32'd0);
        step();
        check_idle("b1_after");
        check("b1_end_address", {22'd0, wr_address}, 32'd5);
        for (int i = 0; i < 3; i++) begin
            issue_read(10'd2 + 10'(i), 1'b1, 8'd10 + 8'(i));
            step();
        end
        oe = 1'b0;

        // Address wrap from the top of memory.
        begin_burst(10'd1022, 10'd4);
        for (int i = 0; i < 4; i++) push_word(8'd1 + 8'(i));
        check("wrap_done", {31'd0, done}, 32'd1);
        check("wrap_end_address", {22'd0, wr_address}, 32'd2);
        step();

        // Backpressure: five idle cycles between two words at base 2.
        begin_burst(10'd2, 10'd2);
        push_word(8'h55);
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp_busy", {31'd0, busy}, 32'd1);
            check("bp_ready", {31'd0, ready}, 32'd1);
            check("bp_done", {31'd0, done}, 32'd0);
            check("bp_address", {22'd0, wr_address}, 32'd3);
        end
        push_word(8'h66);
        check("bp_done_final", {31'd0, done}, 32'd1);
        step();
        check_idle("bp_after");

        // Empty burst.
        begin_burst(10'd50, 10'd0);
        check("empty_done", {31'd0, done}, 32'd1);
        check("empty_ready", {31'd0, ready}, 32'd0);
        check("empty_busy", {31'd0, busy}, 32'd1);
        check("empty_address", {22'd0, wr_address}, 32'd50);
        step();
        check_idle("empty_after");

        // Start pulse during WRITE must be ignored.
        begin_burst(10'd20, 10'd2);
        start = 1'b1; base = 10'd200; count = 10'd5;
        step();
        start = 1'b0;
        check("ign_address", {22'd0, wr_address}, 32'd20);
        check("ign_ready", {31'd0, ready}, 32'd1);
        push_word(8'h21);
        push_word(8'h22);
        check("ign_done", {31'd0, done}, 32'd1);
        step();
        check_idle("ign_after");

        // Reset after the first of three words.
        begin_burst(10'd30, 10'd3);
        push_word(8'h31);
        rst = 1'b1; valid = 1'b1; data = 8'h32;
        step();
        rst = 1'b0; valid = 1'b0;
        check_idle("rst_mid");
        check("rst_mid_address", {22'd0, wr_address}, 32'd0);
        check("rst_mid_out", {24'd0, out}, 32'd0);
        step();
        check("rst_mid_no_done", {31'd0, done}, 32'd0);

        // Same-cycle write and read at address 5: old 7, new 9.
        begin_burst(10'd5, 10'd1);
        push_word(8'd7);
        step();
        begin_burst(10'd5, 10'd1);
        valid = 1'b1; data = 8'd9;
        issue_read(10'd5, 1'b1, 8'd7);
        step();
        valid = 1'b0;
        oe = 1'b0;
        step();

        tbl[0]  = '{10'd2,    1'b1, 8'h55};
        tbl[1]  = '{10'd3,    1'b1, 8'h66};
        tbl[2]  = '{10'd4,    1'b1, 8'd12};
        tbl[3]  = '{10'd4,    1'b0, 8'd0};
        tbl[4]  = '{10'd1022, 1'b1, 8'd1};
        tbl[5]  = '{10'd1023, 1'b1, 8'd2};
        tbl[6]  = '{10'd0,    1'b1, 8'd3};
        tbl[7]  = '{10'd1,    1'b1, 8'd4};
        tbl[8]  = '{10'd20,   1'b1, 8'h21};
        tbl[9]  = '{10'd21,   1'b1, 8'h22};
        tbl[10] = '{10'd30,   1'b1, 8'h31};
        tbl[11] = '{10'd5,    1'b1, 8'd9};
        tbl[12] = '{10'd5,    1'b0, 8'd0};
        for (int i = 0; i < 13; i++) begin
            issue_read(tbl[i].addr, tbl[i].oe, tbl[i].exp);
            step();
        end
        oe = 1'b0;
        step();
        check("queue_drained", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
